// File: rtl/g_arb_pkg.sv
// Shared definitions for the g_3arb3 round-robin arbiter macro.
//   - arb_state_e : arbiter state encoding (IDLE / OWN_A / OWN_B / OWN_C)
//   - IDX_*       : requester indices used by the pointer and the picker
//   - HOLD_W      : width of the consecutive-grant counter
//   - idx_inc     : increment a requester index modulo 3
//   - own_state   : map a requester index to its owning state
//   - state_idx   : map an owning state back to its requester index
package g_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10,
    OWN_C = 2'b11
  } arb_state_e;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;

  localparam int unsigned HOLD_W = 4;

  // Index 3 is never produced; it folds back to A so the picker stays total.
  function automatic logic [1:0] idx_inc(input logic [1:0] idx);
    logic [1:0] nxt;
    unique case (idx)
      IDX_A:   nxt = IDX_B;
      IDX_B:   nxt = IDX_C;
      default: nxt = IDX_A;
    endcase
    return nxt;
  endfunction

  function automatic arb_state_e own_state(input logic [1:0] idx);
    arb_state_e st;
    unique case (idx)
      IDX_A:   st = OWN_A;
      IDX_B:   st = OWN_B;
      default: st = OWN_C;
    endcase
    return st;
  endfunction

  // Only meaningful for the OWN_* states; IDLE maps to A and must be gated.
  function automatic logic [1:0] state_idx(input arb_state_e st);
    logic [1:0] idx;
    unique case (st)
      OWN_B:   idx = IDX_B;
      OWN_C:   idx = IDX_C;
      default: idx = IDX_A;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/g_rr3_pick.sv
// Combinational round-robin next-owner picker for three requesters.
// Search order starts just after the most recent owner: last+1, last+2, last (mod 3).
//   req   : active-high requests, bit i belongs to requester index i
//   last  : index of the most recent owner
//   valid : high when any request is present
//   idx   : chosen requester index (equals last when nothing else qualifies)
module g_rr3_pick
  import g_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] first;
  logic [1:0] second;

  always_comb begin
    first  = idx_inc(last);
    second = idx_inc(first);
    valid  = |req;
    if (req[first]) begin
      idx = first;
    end else if (req[second]) begin
      idx = second;
    end else begin
      idx = last;
    end
  end

endmodule

// File: rtl/g_3arb3.sv
// Three-requester round-robin arbiter with registered active-low grants.
// A programmable hold limit forces a one-cycle idle gap when the owner has held
// for HOLD_MAX cycles and someone else is waiting; a voluntary release hands the
// resource straight to the next requester on the same edge.
//   HOLD_MAX : consecutive grant cycles before preemption (0..15, 0 disables)
//   CLK      : clock, rising edge
//   CDN      : asynchronous clear, active-low
//   AN/BN/CN : requests, active-low
//   GAN/GBN/GCN : grants, active-low, decoded from the state register
//   BUSYN    : low while any grant is low
module g_3arb3
  import g_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic CLK,
  input  logic CDN,
  input  logic AN,
  input  logic BN,
  input  logic CN,
  output logic GAN,
  output logic GBN,
  output logic GCN,
  output logic BUSYN
);

  // Counter value seen at the edge that completes the HOLD_MAX-th grant cycle.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
      (HOLD_MAX == 0) ? '0 : HOLD_W'(HOLD_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  arb_state_e        state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [2:0] req;
  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [1:0] owner_idx;
  logic       owner_req;
  logic       other_req;
  logic       preempt;

  // Inversion to active-high happens here and at the grant outputs only.
  assign req = {~CN, ~BN, ~AN};

  g_rr3_pick u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    owner_idx = state_idx(state_q);
    owner_req = req[owner_idx];
    other_req = |(req & ~(3'b001 << owner_idx));
    preempt   = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST) && owner_req && other_req;
  end

  // State register.
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      state_q    <= IDLE;
      last_q     <= IDX_C;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = own_state(pick_idx);
          last_d     = pick_idx;
          hold_cnt_d = '0;
        end
      end
      OWN_A, OWN_B, OWN_C: begin
        if (!owner_req) begin
          // Release wins over preemption. last_q is the owner and the owner is
          // not requesting, so the picker can only return another requester.
          if (pick_valid) begin
            state_d = own_state(pick_idx);
            last_d  = pick_idx;
          end else begin
            state_d = IDLE;
          end
          hold_cnt_d = '0;
        end else if (preempt) begin
          // last_q stays on the owner, giving it lowest priority next time.
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode, purely from the registered state.
  always_comb begin
    GAN   = (state_q != OWN_A);
    GBN   = (state_q != OWN_B);
    GCN   = (state_q != OWN_C);
    BUSYN = GAN & GBN & GCN;
  end

endmodule

// File: tb/tb_g_3arb3.sv
// Directed bench for g_3arb3. Two instances share clock, reset and requests:
// u_dut0 with HOLD_MAX=0 (no preemption) and u_dut4 with HOLD_MAX=4.
// Observed outputs are packed as {BUSYN, GAN, GBN, GCN}.
module tb_g_3arb3;

  localparam logic [3:0] G_NONE = 4'b1111;
  localparam logic [3:0] G_A    = 4'b0011;
  localparam logic [3:0] G_B    = 4'b0101;
  localparam logic [3:0] G_C    = 4'b0110;

  logic clk;
  logic cdn;
  logic an, bn, cn;
  logic gan0, gbn0, gcn0, busyn0;
  logic gan4, gbn4, gcn4, busyn4;

  int n_checks;
  int n_fail;

  g_3arb3 #(.HOLD_MAX(0)) u_dut0 (
    .CLK   (clk),
    .CDN   (cdn),
    .AN    (an),
    .BN    (bn),
    .CN    (cn),
    .GAN   (gan0),
    .GBN   (gbn0),
    .GCN   (gcn0),
    .BUSYN (busyn0)
  );

  g_3arb3 #(.HOLD_MAX(4)) u_dut4 (
    .CLK   (clk),
    .CDN   (cdn),
    .AN    (an),
    .BN    (bn),
    .CN    (cn),
    .GAN   (gan4),
    .GBN   (gbn4),
    .GCN   (gcn4),
    .BUSYN (busyn4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] obs0();
    return {busyn0, gan0, gbn0, gcn0};
  endfunction

  function automatic logic [3:0] obs4();
    return {busyn4, gan4, gbn4, gcn4};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and check the asynchronous clear on both DUTs.
  task automatic reset_pulse(input string tag);
    cdn = 1'b0;
    #1;
    check({tag, "_rst0"}, obs0(), G_NONE);
    check({tag, "_rst4"}, obs4(), G_NONE);
    cdn = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    an  = 1'b1;
    bn  = 1'b1;
    cn  = 1'b1;
    cdn = 1'b0;
    #3;
    check("por0", obs0(), G_NONE);
    check("por4", obs4(), G_NONE);
    #9;
    cdn = 1'b1;

    // Single request and release.
    an = 1'b0;
    tick();
    check("single_grant", obs0(), G_A);
    check("single_grant4", obs4(), G_A);
    an = 1'b1;
    tick();
    check("single_release", obs0(), G_NONE);

    // Simultaneous requests: A first, then same-edge handoff A->B->C.
    reset_pulse("sim");
    an = 1'b0; bn = 1'b0; cn = 1'b0;
    tick();
    check("sim_a", obs0(), G_A);
    an = 1'b1;
    tick();
    check("sim_b", obs0(), G_B);
    check("sim_b4", obs4(), G_B);
    bn = 1'b1;
    tick();
    check("sim_c", obs0(), G_C);
    cn = 1'b1;
    tick();
    check("sim_idle", obs0(), G_NONE);

    // Round-robin fairness on the HOLD_MAX=0 instance.
    reset_pulse("rr");
    an = 1'b0; bn = 1'b0; cn = 1'b0;
    tick();
    check("rr_a1", obs0(), G_A);
    check("rr_last_a1", {2'b00, u_dut0.last_q}, 4'd0);
    tick();
    check("rr_a1_hold", obs0(), G_A);
    an = 1'b1;
    tick();
    check("rr_b1", obs0(), G_B);
    check("rr_last_b1", {2'b00, u_dut0.last_q}, 4'd1);
    an = 1'b0;
    tick();
    check("rr_b1_hold1", obs0(), G_B);
    tick();
    check("rr_b1_hold2", obs0(), G_B);
    bn = 1'b1;
    tick();
    check("rr_c", obs0(), G_C);
    check("rr_last_c", {2'b00, u_dut0.last_q}, 4'd2);
    bn = 1'b0;
    tick();
    check("rr_c_hold1", obs0(), G_C);
    tick();
    check("rr_c_hold2", obs0(), G_C);
    cn = 1'b1;
    tick();
    check("rr_a2", obs0(), G_A);
    check("rr_last_a2", {2'b00, u_dut0.last_q}, 4'd0);
    tick();
    check("rr_a2_hold", obs0(), G_A);
    an = 1'b1;
    tick();
    check("rr_b2", obs0(), G_B);
    check("rr_last_b2", {2'b00, u_dut0.last_q}, 4'd1);
    bn = 1'b1;
    tick();
    check("rr_idle", obs0(), G_NONE);

    // Preemption: HOLD_MAX=4, A holds, B pending from cycle 2.
    reset_pulse("pre");
    an = 1'b0;
    tick();
    check("pre_a1", obs4(), G_A);
    bn = 1'b0;
    tick();
    check("pre_a2", obs4(), G_A);
    tick();
    check("pre_a3", obs4(), G_A);
    tick();
    check("pre_a4", obs4(), G_A);
    tick();
    check("pre_gap", obs4(), G_NONE);
    check("pre_nohold0", obs0(), G_A);
    tick();
    check("pre_b", obs4(), G_B);
    an = 1'b1; bn = 1'b1;
    tick();
    check("pre_idle", obs4(), G_NONE);

    // Release on the same edge preemption would fire: handoff, no gap.
    reset_pulse("col");
    an = 1'b0; bn = 1'b0;
    tick();
    check("col_a1", obs4(), G_A);
    tick();
    tick();
    tick();
    check("col_a4", obs4(), G_A);
    an = 1'b1;
    tick();
    check("col_b", obs4(), G_B);
    bn = 1'b1;
    tick();
    check("col_idle", obs4(), G_NONE);

    // Asynchronous reset mid-grant, then pointer restarts at C.
    reset_pulse("arst");
    cn = 1'b0;
    tick();
    check("arst_c", obs0(), G_C);
    #2;
    cdn = 1'b0;
    #1;
    check("arst_drop0", obs0(), G_NONE);
    check("arst_drop4", obs4(), G_NONE);
    an = 1'b0; bn = 1'b0; cn = 1'b0;
    #1;
    cdn = 1'b1;
    tick();
    check("arst_a", obs0(), G_A);
    check("arst_a4", obs4(), G_A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
